uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
- Shares one 8N1 UART transmit path between two byte requesters. The arbitration is round-robin.
- Owns the baud counter. The counter is held cleared while idle and restarts at every frame start, so bit edges are phase-locked to frame start.
- Sits between the FIFO read side and the txd pin.
- Serialises the granted byte LSB first and reports the served source plus a frame-done pulse.

Parameters:
- CLK_DIV, 5208, clock cycles per bit (50 MHz / 9600 bps); legal range 2..8191.
- CNT_W, 13, baud counter width; must satisfy 2^CNT_W >= CLK_DIV.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  when low, no new frame is granted; a frame in flight completes.
- req0  input  1  requester 0 has a byte; held until ack0.
- data0  input  8  requester 0 byte; must be valid while req0=1.
- ack0  output  1  one-cycle pulse: data0 captured.
- req1  input  1  requester 1 has a byte; held until ack1.
- data1  input  8  requester 1 byte.
- ack1  output  1  one-cycle pulse: data1 captured.
- txd  output  1  serial line; idle high.
- busy  output  1  high from START entry until frame end.
- src  output  1  source of the current or last frame (0/1).
- frame_done  output  1  one-cycle pulse in the last cycle of the stop bit.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, cnt=0, bit_idx=0, txd=1, busy=0, ack0=ack1=0, src=0, frame_done=0, last_grant=1 (so req0 wins the first tie).
  - Reset mid-frame aborts the frame: txd=1 on the next cycle, no ack and no frame_done.
- States and bit timing:
  - States: IDLE, START, DATA, STOP.
  - cnt counts 0..CLK_DIV-1 in START, DATA and STOP; it is forced to 0 in IDLE and on every START entry.
  - bit_end = (cnt==CLK_DIV-1).
  - Every bit lasts exactly CLK_DIV cycles. A frame is 10*CLK_DIV cycles.
- Arbitration point:
  - Evaluated in any IDLE cycle, and in the STOP cycle where bit_end=1.
  - Grant requires en=1 and at least one req.
  - Only one requester: that one is granted.
  - Both requesting: grant !last_grant.
  - On grant: last_grant<=g, src<=g, shreg<=data_g, ack_g<=1 for exactly the next cycle, state<=START.
- Outputs per state:
  - IDLE: txd=1, busy=0.
  - START: txd=0. On bit_end, go to DATA with bit_idx=0.
  - DATA: txd=shreg[0]. On bit_end, shift shreg right; bit_idx increments; after bit_idx==7, go to STOP.
  - STOP: txd=1. On bit_end, frame_done=1 that cycle; then START if granted, else IDLE.
- Back-to-back frames: a grant at STOP end gives zero idle gap; the stop bit is exactly CLK_DIV cycles.
- Latency: req seen in IDLE at cycle T gives ack and txd=0 in cycle T+1. The first data bit starts at T+1+CLK_DIV.
- Requester rule: deassert req, or present the next byte, in the cycle after seeing ack.
  - req is not re-sampled before the next arbitration point, so a held req means a stream of frames.
  - Dropping req without an ack is allowed; nothing is captured.
- en and data stability:
  - en low only blocks grants. en toggling mid-frame has no effect on the frame.
  - data_g changing after capture has no effect.
- txd, ack*, frame_done, busy and src are registered outputs (glitch-free on the pin).

Test Plan (CLK_DIV=4 unless noted):
- Reset, then req0=1 with data0=8'hA5 for one grant -> ack0 pulses 1 cycle after req.
  - txd over 40 cycles: 0 x4, then 1,0,1,0,0,1,0,1 each x4, then 1 x4.
  - frame_done in cycle 40 of the frame; busy=1 throughout.
- req0 and req1 both held, data0=8'h11, data1=8'h22 -> frames alternate 11,22,11,22 with src 0,1,0,1.
  - No idle cycle between frames; each ack once per frame.
- Reset asserted at cycle 17 of a frame -> next cycle txd=1, busy=0, no frame_done.
  - A new req afterwards goes to req0 first on a tie.
- en=0 with req1=1 -> no ack, txd stays 1.
  - en dropped mid-frame -> frame completes and no further grant.
  - en raised -> ack1 on the next cycle.
- req1 arrives during a req0 frame and req0 drops after its ack -> req1 is granted exactly at STOP bit_end, gap-free.
- CLK_DIV=5208 with byte 8'h00 -> the start bit plus 8 data bits give 46872 cycles low, then 5208 cycles high.

Source files
------------

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: one 8N1 UART transmitter shared by two byte requesters.
// Round-robin arbitration at every frame boundary, LSB-first serialisation,
// baud counter phase-locked to the start of each frame. All outputs are
// registered so the txd pin never glitches.
module uart_tx_sched #(
  parameter int CLK_DIV = 5208,
  parameter int CNT_W   = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       txd,
  output logic       busy,
  output logic       src,
  output logic       frame_done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             last_grant, last_grant_n;
  logic             src_n;
  logic             ack0_n, ack1_n;
  logic             txd_n, busy_n, frame_done_n;

  logic             bit_end;
  logic             arb_point;
  logic             grant_valid;
  logic             grant_sel;

  // Arbitration decision: a frame boundary (idle or the final stop-bit
  // cycle) with the enable high and at least one requester waiting.
  // On a tie the requester that was not served last time wins.
  always_comb begin
    bit_end     = (cnt == CNT_LAST);
    arb_point   = (state == IDLE) || ((state == STOP) && bit_end);
    grant_valid = arb_point && en && (req0 || req1);
    grant_sel   = (req0 && req1) ? ~last_grant : req1;
  end

  // Next-state logic for the frame sequencer, the baud counter, the shift
  // register and the arbiter bookkeeping; a grant overrides the normal
  // end-of-frame return to IDLE so back-to-back frames have no gap.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    bit_idx_n    = bit_idx;
    shreg_n      = shreg;
    last_grant_n = last_grant;
    src_n        = src;
    ack0_n       = 1'b0;
    ack1_n       = 1'b0;

    case (state)
      IDLE: begin
        cnt_n = '0;
      end
      START: begin
        if (bit_end) begin
          state_n   = DATA;
          cnt_n     = '0;
          bit_idx_n = 3'd0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n     = '0;
          shreg_n   = {1'b0, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    if (grant_valid) begin
      state_n      = START;
      cnt_n        = '0;
      last_grant_n = grant_sel;
      src_n        = grant_sel;
      shreg_n      = grant_sel ? data1 : data0;
      ack0_n       = ~grant_sel;
      ack1_n       = grant_sel;
    end
  end

  // Output values are derived from the next state so that, once registered,
  // they line up exactly with the state they describe.
  always_comb begin
    txd_n = 1'b1;
    case (state_n)
      IDLE:    txd_n = 1'b1;
      START:   txd_n = 1'b0;
      DATA:    txd_n = shreg_n[0];
      STOP:    txd_n = 1'b1;
      default: txd_n = 1'b1;
    endcase
    busy_n       = (state_n != IDLE);
    frame_done_n = (state_n == STOP) && (cnt_n == CNT_LAST);
  end

  // Sequencer, counter, shift register and arbiter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shreg      <= 8'd0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      last_grant <= last_grant_n;
    end
  end

  // Registered outputs driving the pin and the requester handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      txd        <= 1'b1;
      busy       <= 1'b0;
      src        <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      txd        <= txd_n;
      busy       <= busy_n;
      src        <= src_n;
      ack0       <= ack0_n;
      ack1       <= ack1_n;
      frame_done <= frame_done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched: a frame-level reference model checked every
// cycle, directed scenarios with hand-computed expectations, a randomized
// requester phase, and one long frame at the real 9600-baud divider.
module tb_uart_tx_sched;

  localparam int D   = 4;
  localparam int BIG = 5208;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   = 1'b1;
  logic       en    = 1'b0;
  logic       req0  = 1'b0;
  logic       req1  = 1'b0;
  logic [7:0] data0 = 8'h00;
  logic [7:0] data1 = 8'h00;
  logic       ack0, ack1, txd, busy, src, frame_done;

  logic       rst_b   = 1'b1;
  logic       en_b    = 1'b0;
  logic       req0_b  = 1'b0;
  logic       req1_b  = 1'b0;
  logic [7:0] data0_b = 8'h00;
  logic [7:0] data1_b = 8'h00;
  logic       ack0_b, ack1_b, txd_b, busy_b, src_b, fd_b;

  uart_tx_sched #(.CLK_DIV(D), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .txd(txd), .busy(busy), .src(src), .frame_done(frame_done)
  );

  uart_tx_sched #(.CLK_DIV(BIG), .CNT_W(13)) dut_big (
    .clk(clk), .rst(rst_b), .en(en_b),
    .req0(req0_b), .data0(data0_b), .ack0(ack0_b),
    .req1(req1_b), .data1(data1_b), .ack1(ack1_b),
    .txd(txd_b), .busy(busy_b), .src(src_b), .frame_done(fd_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a frame is just "active at position p of 10*D cycles".
  bit         m_valid  = 1'b0;
  bit         m_active = 1'b0;
  int         m_pos    = 0;
  logic       m_last   = 1'b1;
  logic       m_src    = 1'b0;
  logic [7:0] m_byte   = 8'h00;
  logic       m_ack0   = 1'b0;
  logic       m_ack1   = 1'b0;
  logic       m_g;
  bit         m_arb;

  function automatic logic bit_at(input int pos, input logic [7:0] b);
    int k;
    k = pos / D;
    if (k == 0) return 1'b0;
    else if (k <= 8) return b[k-1];
    else return 1'b1;
  endfunction

  // Advance the model on every rising edge using the inputs the DUT sees.
  always @(posedge clk) begin
    if (rst) begin
      m_valid  = 1'b1;
      m_active = 1'b0;
      m_pos    = 0;
      m_last   = 1'b1;
      m_src    = 1'b0;
      m_ack0   = 1'b0;
      m_ack1   = 1'b0;
    end else if (m_valid) begin
      m_ack0 = 1'b0;
      m_ack1 = 1'b0;
      m_arb  = !m_active || (m_pos == 10*D-1);
      if (m_arb && en && (req0 || req1)) begin
        m_g      = (req0 && req1) ? ~m_last : req1;
        m_last   = m_g;
        m_src    = m_g;
        m_byte   = m_g ? data1 : data0;
        m_active = 1'b1;
        m_pos    = 0;
        if (m_g) m_ack1 = 1'b1;
        else     m_ack0 = 1'b1;
      end else if (m_arb) begin
        m_active = 1'b0;
        m_pos    = 0;
      end else begin
        m_pos = m_pos + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: move to the falling edge and compare the DUT against the model.
  task automatic tick();
    logic [5:0] act, exp;
    @(negedge clk);
    if (m_valid) begin
      act = {ack0, ack1, txd, busy, src, frame_done};
      exp = {m_ack0, m_ack1,
             m_active ? bit_at(m_pos, m_byte) : 1'b1,
             m_active, m_src,
             m_active && (m_pos == 10*D-1)};
      checkOutput("model", {58'd0, act}, {58'd0, exp});
    end
  endtask

  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      tick();
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 59) == 0) en = ~en;
      if (req0) begin
        if (ack0) begin
          if ($urandom_range(0, 1) == 0) req0 = 1'b0;
          else data0 = 8'($urandom);
        end else if ($urandom_range(0, 199) == 0) begin
          req0 = 1'b0;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        req0  = 1'b1;
        data0 = 8'($urandom);
      end
      if (req1) begin
        if (ack1) begin
          if ($urandom_range(0, 1) == 0) req1 = 1'b0;
          else data1 = 8'($urandom);
        end else if ($urandom_range(0, 199) == 0) begin
          req1 = 1'b0;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        req1  = 1'b1;
        data1 = 8'($urandom);
      end
    end
  endtask

  initial begin
    logic [39:0] txd_seq;
    logic [3:0]  src_seq;
    logic        busy_and;
    int fd_at, ack_at, k, fdn, span, idle, both, acks, fds, low, high;
    bit fd_seen;

    // Single frame of 8'hA5 after reset.
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checkOutput("reset_state", {58'd0, ack0, ack1, txd, busy, src, frame_done}, 64'b001000);
    en = 1'b1; req0 = 1'b1; data0 = 8'hA5;
    busy_and = 1'b1; fd_at = 0; txd_seq = '0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) begin
        checkOutput("a5_ack0", {62'd0, ack0, ack1}, 64'b10);
        req0 = 1'b0;
      end
      txd_seq[c-1] = txd;
      busy_and &= busy;
      if (frame_done) fd_at = c;
    end
    checkOutput("a5_txd_seq", {24'd0, txd_seq}, 64'hFF0F00F0F0);
    checkOutput("a5_fd_cycle", fd_at, 40);
    checkOutput("a5_busy", busy_and, 1);
    tick();
    checkOutput("a5_idle_after", {58'd0, ack0, ack1, txd, busy, src, frame_done}, 64'b001000);

    // Both requesters held: alternating, gap-free frames.
    rst = 1'b1; tick(); rst = 1'b0;
    req0 = 1'b1; data0 = 8'h11; req1 = 1'b1; data1 = 8'h22;
    k = 0; fdn = 0; span = 0; idle = 0; both = 0; src_seq = '0;
    for (int c = 0; c < 400 && fdn < 4; c++) begin
      tick();
      if (k > 0) begin
        span++;
        if (!busy) idle++;
      end
      if (ack0 || ack1) begin
        if (k < 4) src_seq[k] = src;
        if (ack0 && ack1) both++;
        k++;
        if (k == 1) span = 1;
        if (k >= 4) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
      if (frame_done) fdn++;
    end
    checkOutput("rr_src_seq", src_seq, 64'b1010);
    checkOutput("rr_ack_count", k, 4);
    checkOutput("rr_span", span, 160);
    checkOutput("rr_idle", idle, 0);
    checkOutput("rr_both", both, 0);
    repeat (3) tick();

    // Reset in cycle 17 of a frame aborts it; req0 wins the next tie.
    req0 = 1'b1; data0 = 8'h3C;
    tick();
    checkOutput("abort_ack0", {62'd0, ack0, ack1}, 64'b10);
    req0 = 1'b0;
    for (int c = 2; c <= 17; c++) tick();
    rst = 1'b1;
    tick();
    checkOutput("abort_state", {58'd0, ack0, ack1, txd, busy, src, frame_done}, 64'b001000);
    rst = 1'b0; req0 = 1'b1; data0 = 8'h81; req1 = 1'b1; data1 = 8'h42;
    tick();
    checkOutput("abort_tie", {61'd0, ack0, ack1, src}, 64'b100);
    req0 = 1'b0; req1 = 1'b0;
    repeat (45) tick();

    // Enable gating.
    en = 1'b0; req1 = 1'b1; data1 = 8'h5A;
    acks = 0; low = 0;
    repeat (10) begin
      tick();
      if (ack0 || ack1) acks++;
      if (!txd) low++;
    end
    checkOutput("en_blocked_ack", acks, 0);
    checkOutput("en_blocked_txd", low, 0);
    en = 1'b1;
    tick();
    checkOutput("en_ack1", {61'd0, ack0, ack1, src}, 64'b011);
    data1 = 8'h96;
    repeat (5) tick();
    en = 1'b0;
    acks = 0; fds = 0;
    repeat (80) begin
      tick();
      if (ack0 || ack1) acks++;
      if (frame_done) fds++;
    end
    checkOutput("en_mid_fd", fds, 1);
    checkOutput("en_mid_noack", acks, 0);
    checkOutput("en_mid_idle", {62'd0, txd, busy}, 64'b10);
    req1 = 1'b0; en = 1'b1;
    tick();

    // req1 arrives mid-frame and is served exactly at the stop-bit end.
    req0 = 1'b1; data0 = 8'hC3;
    tick();
    checkOutput("hand_ack0", {62'd0, ack0, ack1}, 64'b10);
    req0 = 1'b0;
    fd_at = 0; ack_at = 0; idle = 0;
    for (int c = 2; c < 100; c++) begin
      tick();
      if (c == 10) begin
        req1 = 1'b1;
        data1 = 8'h7E;
      end
      if (!busy) idle++;
      if (frame_done) fd_at = c;
      if (ack1) begin
        ack_at = c;
        break;
      end
    end
    checkOutput("hand_fd_cycle", fd_at, 40);
    checkOutput("hand_ack1_cycle", ack_at, 41);
    checkOutput("hand_gap", idle, 0);
    req1 = 1'b0;
    repeat (45) tick();

    // Randomized traffic against the model.
    applyStimulus(3000);
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; en = 1'b1;
    repeat (50) tick();

    // Real divider: byte 8'h00 gives 9 low bits then one high stop bit.
    tick();
    rst_b = 1'b0; en_b = 1'b1; req0_b = 1'b1; data0_b = 8'h00;
    fd_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ack0_b) begin
        fd_seen = 1'b1;
        break;
      end
    end
    checkOutput("big_ack", fd_seen, 1);
    checkOutput("big_src", {62'd0, ack1_b, src_b}, 0);
    req0_b = 1'b0;
    low = 0;
    while (txd_b === 1'b0 && low < 60000) begin
      low++;
      tick();
    end
    high = 0; fd_seen = 1'b0;
    while (high < 6000) begin
      high++;
      if (fd_b) begin
        fd_seen = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("big_low_cycles", low, 46872);
    checkOutput("big_high_cycles", high, 5208);
    checkOutput("big_fd_seen", fd_seen, 1);
    tick();
    checkOutput("big_idle", {62'd0, busy_b, txd_b}, 64'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
